uart_tx_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 45 ++++
 rtl/uart_tx_shift.sv | 55 +++++
 rtl/uart_tx_ctrl.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity modes, default
// frame parameters and the parity helper, for transmitter and receiver.
package uart_pkg;

    // Frame sequencing states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Parity modes
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Default frame format
    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_BITS    = 8;
    localparam int DEF_PARITY       = PAR_NONE;
    localparam int DEF_STOP_BITS    = 1;

    // Parity over the low nbits of data: XOR for even, inverted XOR for odd.
    // Returns 0 when parity is disabled.
    function automatic logic parity_bit(input logic [7:0] data,
                                        input int         nbits,
                                        input int         mode);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < nbits) begin
                acc = acc ^ data[i];
            end
        end
        if (mode == PAR_ODD) begin
            return ~acc;
        end else if (mode == PAR_EVEN) begin
            return acc;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/uart_tx_shift.sv
// Parallel-in / serial-out shift register for the UART transmitter.
// Loads a whole character, shifts right one place per shift strobe and
// presents bit 0 as the current serial bit. next_o exposes bit 1, the bit
// that becomes current after the next shift, so the controller can
// register the line value in the same edge the register shifts.
module uart_tx_shift
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 shift_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 serial_o,
    output logic                 next_o
);

    logic [DATA_BITS-1:0] data_q;
    logic [DATA_BITS-1:0] data_d;
    logic [DATA_BITS-1:0] shifted;

    // Right-shift network; a zero fills in from the top
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_bit
        if (gi == DATA_BITS - 1) begin : g_top
            assign shifted[gi] = 1'b0;
        end else begin : g_mid
            assign shifted[gi] = data_q[gi + 1];
        end
    end

    // Next register value: load has priority over shift
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = data_i;
        end else if (shift_i) begin
            data_d = shifted;
        end
    end

    // Register update with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign serial_o = data_q[0];
    assign next_o   = data_q[1];

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller. Accepts a character on a valid/ready handshake
// and emits start bit, data bits LSB first, optional parity bit and stop
// bit(s), each exactly CLKS_PER_BIT cycles long. The line and all status
// outputs come straight from flops; every line value is registered on the
// edge that enters the corresponding bit period.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int PARITY       = DEF_PARITY,
    parameter int STOP_BITS    = DEF_STOP_BITS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST  = 1'(STOP_BITS - 1);
    localparam bit                HAS_PARITY = (PARITY != PAR_NONE);

    uart_state_e       state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [BIT_W-1:0]  bit_q;
    logic              stop_q;
    logic              parity_q;
    logic              tx_q;
    logic              busy_q;
    logic              ready_q;
    logic              done_q;

    logic              accept;
    logic              bit_end;
    logic              shift_en;
    logic              sr_serial;
    logic              sr_next;

    // A byte is taken only while idle; requests at other times are ignored
    assign accept   = tx_valid & ready_q;
    // Last cycle of the current bit period
    assign bit_end  = (baud_q == BAUD_LAST);
    // Advance the data register at every data bit boundary
    assign shift_en = (state_q == ST_DATA) & bit_end;

    uart_tx_shift #(
        .DATA_BITS (DATA_BITS)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load_i   (accept),
        .shift_i  (shift_en),
        .data_i   (tx_data[DATA_BITS-1:0]),
        .serial_o (sr_serial),
        .next_o   (sr_next)
    );

    // Frame sequencer with baud/bit/stop counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Baud counter free-runs within a frame; wraps at each bit end
            if (state_q != ST_IDLE) begin
                if (bit_end) begin
                    baud_q <= '0;
                end else begin
                    baud_q <= baud_q + 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (accept) begin
                        state_q  <= ST_START;
                        baud_q   <= '0;
                        bit_q    <= '0;
                        stop_q   <= 1'b0;
                        parity_q <= parity_bit(tx_data, DATA_BITS, PARITY);
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        ready_q  <= 1'b0;
                    end
                end

                ST_START: begin
                    if (bit_end) begin
                        state_q <= ST_DATA;
                        tx_q    <= sr_serial;
                    end
                end

                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_q == BIT_LAST) begin
                            bit_q <= '0;
                            if (HAS_PARITY) begin
                                state_q <= ST_PARITY;
                                tx_q    <= parity_q;
                            end else begin
                                state_q <= ST_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            tx_q  <= sr_next;
                        end
                    end
                end

                ST_PARITY: begin
                    if (bit_end) begin
                        state_q <= ST_STOP;
                        tx_q    <= 1'b1;
                    end
                end

                ST_STOP: begin
                    if (bit_end) begin
                        if (stop_q == STOP_LAST) begin
                            state_q <= ST_IDLE;
                            stop_q  <= 1'b0;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            stop_q <= stop_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign tx_busy  = busy_q;
    assign tx_ready = ready_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl. Four instances cover no/even/odd parity with
// 8 data bits and 1 stop bit, plus 7 data bits with 2 stop bits, all at
// 4 clocks per bit. Stimulus queues the expected frame (line level per bit
// slot, written in time order) before sending; a monitor detects each
// accept, captures the whole frame cycle by cycle and compares.
module tb_uart_tx_ctrl;

    localparam int CPB = 4;
    localparam int NDUT = 4;

    logic       clk = 1'b0;
    logic       rst      [NDUT];
    logic [7:0] tx_data  [NDUT];
    logic       tx_valid [NDUT];
    logic       tx_ready [NDUT];
    logic       tx_line  [NDUT];
    logic       tx_busy  [NDUT];
    logic       tx_done  [NDUT];

    int          exp_idx  [$];
    logic [15:0] exp_bits [$];
    int          exp_len  [$];

    int n_chk = 0;
    int n_err = 0;
    bit mon_en = 1'b1;
    bit mon_busy = 1'b0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int P = (gi == 1) ? 1 : ((gi == 2) ? 2 : 0);
        localparam int D = (gi == 3) ? 7 : 8;
        localparam int S = (gi == 3) ? 2 : 1;
        uart_tx_ctrl #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (D),
            .PARITY       (P),
            .STOP_BITS    (S)
        ) u_dut (
            .clk      (clk),
            .rst      (rst[gi]),
            .tx_data  (tx_data[gi]),
            .tx_valid (tx_valid[gi]),
            .tx_ready (tx_ready[gi]),
            .tx       (tx_line[gi]),
            .tx_busy  (tx_busy[gi]),
            .tx_done  (tx_done[gi])
        );
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_chk++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    // Queue one expected frame; s lists the line level of each bit slot
    task automatic expect_frame(input int i, input string s);
        logic [15:0] b;
        b = '0;
        for (int k = 0; k < s.len(); k++) begin
            b[k] = (s[k] == 8'h31);
        end
        exp_idx.push_back(i);
        exp_bits.push_back(b);
        exp_len.push_back(s.len());
    endtask

    // Called at posedge+1; returns in cycle 1 of the frame (posedge+1 after E0)
    task automatic send(input int i, input logic [7:0] d);
        int t;
        t = 0;
        while (!tx_ready[i] && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!tx_ready[i]) begin
            check("send_ready_timeout", 32'(tx_ready[i]), 32'd1);
        end else begin
            tx_valid[i] = 1'b1;
            tx_data[i]  = d;
            @(posedge clk); #1;
            tx_valid[i] = 1'b0;
        end
    endtask

    // Wait until every queued frame has been seen and checked
    task automatic drain();
        int t;
        t = 0;
        while ((exp_idx.size() != 0 || mon_busy) && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_pending_frames", 32'(exp_idx.size()) + 32'(mon_busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: captures each accepted frame and compares with the queue
    initial begin : monitor
        bit          have;
        int          i, ei, len, f;
        int          tx_bad_n, busy_bad_n, rdy_bad_n, done_bad_n;
        logic        tx_bad_got, tx_bad_req, exp_tx;
        logic [15:0] bits;
        logic [3:0]  end_flags;
        have = 1'b0;
        forever begin
            if (!have) @(negedge clk);
            have = 1'b0;
            i = -1;
            for (int k = 0; k < NDUT; k++) begin
                if (tx_valid[k] && tx_ready[k] && !rst[k]) i = k;
            end
            if (mon_en && i >= 0) begin
                mon_busy = 1'b1;
                if (exp_idx.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_frame: dut %0d accepted 0x%h, required no accept", i, tx_data[i]);
                end else begin
                    ei   = exp_idx.pop_front();
                    bits = exp_bits.pop_front();
                    len  = exp_len.pop_front();
                    f    = len * CPB;
                    check("frame_dut", 32'(i), 32'(ei));
                    tx_bad_n = 0; busy_bad_n = 0; rdy_bad_n = 0; done_bad_n = 0;
                    tx_bad_got = 1'b0; tx_bad_req = 1'b0;
                    end_flags = '0;
                    for (int n = 1; n <= f + 1; n++) begin
                        @(negedge clk);
                        if (n <= f) begin
                            exp_tx = bits[(n - 1) / CPB];
                            if (tx_line[i] !== exp_tx && tx_bad_n == 0) begin
                                tx_bad_n = n; tx_bad_got = tx_line[i]; tx_bad_req = exp_tx;
                            end
                            if (tx_busy[i] !== 1'b1 && busy_bad_n == 0) busy_bad_n = n;
                            if (tx_ready[i] !== 1'b0 && rdy_bad_n == 0) rdy_bad_n = n;
                            if (tx_done[i] !== 1'b0 && done_bad_n == 0) done_bad_n = n;
                        end else begin
                            end_flags = {tx_line[i], tx_busy[i], tx_ready[i], tx_done[i]};
                        end
                    end
                    n_chk++;
                    if (tx_bad_n != 0) begin
                        n_err++;
                        $display("FAIL tx_pattern: dut %0d cycle %0d got tx=%b required %b", i, tx_bad_n, tx_bad_got, tx_bad_req);
                    end
                    n_chk++;
                    if (busy_bad_n != 0) begin
                        n_err++;
                        $display("FAIL busy_window: dut %0d tx_busy low at cycle %0d, required high in 1..%0d", i, busy_bad_n, f);
                    end
                    n_chk++;
                    if (rdy_bad_n != 0) begin
                        n_err++;
                        $display("FAIL ready_window: dut %0d tx_ready high at cycle %0d, required low in 1..%0d", i, rdy_bad_n, f);
                    end
                    n_chk++;
                    if (done_bad_n != 0) begin
                        n_err++;
                        $display("FAIL early_done: dut %0d tx_done high at cycle %0d, required only at %0d", i, done_bad_n, f + 1);
                    end
                    n_chk++;
                    if (end_flags !== 4'b1011) begin
                        n_err++;
                        $display("FAIL done_cycle: dut %0d cycle %0d got {tx,busy,ready,done}=%b required 1011", i, f + 1, end_flags);
                    end
                    have = 1'b1;
                end
                mon_busy = 1'b0;
            end
        end
    end

    // Directed stimulus
    initial begin : stimulus
        int cnt, lows, dones;
        for (int k = 0; k < NDUT; k++) begin
            rst[k] = 1'b1; tx_valid[k] = 1'b0; tx_data[k] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) rst[k] = 1'b0;

        // Reset state of every instance: {tx,busy,ready,done}
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("reset_state_dut%0d", k),
                  {28'd0, tx_line[k], tx_busy[k], tx_ready[k], tx_done[k]}, 32'b1010);
        end

        // Basic frame, no parity
        expect_frame(0, "0101001011");
        send(0, 8'hA5);
        drain();

        // Even and odd parity
        expect_frame(1, "01010010101");
        send(1, 8'hA5);
        drain();
        expect_frame(2, "01010010111");
        send(2, 8'hA5);
        drain();
        expect_frame(1, "01000000011");
        send(1, 8'h01);
        drain();

        // Back-to-back with tx_valid held high
        expect_frame(0, "0000000001");
        expect_frame(0, "0111111111");
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h00;
        @(posedge clk); #1;
        tx_data[0] = 8'hFF;
        cnt = 1;
        while (!tx_ready[0] && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("b2b_ready_cycle", 32'(cnt), 32'd41);
        @(posedge clk); #1;
        tx_valid[0] = 1'b0;
        drain();

        // Request while busy is ignored
        expect_frame(0, "0011010011");
        send(0, 8'h96);
        repeat (9) @(posedge clk);
        #1;
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h3C;
        @(posedge clk); #1;
        tx_valid[0] = 1'b0;
        drain();
        lows = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (tx_line[0] !== 1'b1) lows++;
        end
        check("no_second_frame_low_cycles", 32'(lows), 32'd0);

        // Reset in cycle 15 of a 0x55 frame
        mon_en = 1'b0;
        send(0, 8'h55);
        repeat (14) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        check("abort_state", {28'd0, tx_line[0], tx_busy[0], tx_ready[0], tx_done[0]}, 32'b1010);
        rst[0] = 1'b0;
        lows = 0;
        dones = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (tx_line[0] !== 1'b1) lows++;
            if (tx_done[0] !== 1'b0) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        check("abort_line_idle", 32'(lows), 32'd0);
        @(posedge clk); #1;
        mon_en = 1'b1;
        expect_frame(0, "0100000011");
        send(0, 8'h81);
        drain();

        // 7 data bits, 2 stop bits; bit 7 of tx_data ignored
        expect_frame(3, "0111111111");
        send(3, 8'h7F);
        drain();
        expect_frame(3, "0101000011");
        send(3, 8'h85);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
